// File: rtl/pwr_toggle_monitor_pkg.sv
// Shared types and helpers for the switching-activity monitors.
// Holds the monitor FSM encoding, default widths and saturating add.
package pwr_mon_pkg;

    localparam int NET_W_D = 16;
    localparam int CNT_W_D = 24;
    localparam int WIN_W_D = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_ACCUM,
        S_REPORT
    } mon_state_e;

    // Result is {overflow, clamped sum}; clamped never exceeds max.
    function automatic logic [32:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] max
    );
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max}) begin
            sat_add = {1'b1, max};
        end else begin
            sat_add = {1'b0, sum[31:0]};
        end
    endfunction

endpackage

// File: rtl/pwr_toggle_monitor_if.sv
// Sample stream, control and result port of the toggle monitor.
// master = harness side, slave = monitor side.
interface pwr_toggle_monitor_if #(
    parameter int NET_W = 16,
    parameter int CNT_W = 24,
    parameter int WIN_W = 16
) ();

    logic             start;
    logic [WIN_W-1:0] cfg_window;
    logic             in_valid;
    logic             in_ready;
    logic [NET_W-1:0] in_vec;
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] res_toggles;
    logic [CNT_W-1:0] res_out_toggles;
    logic             res_sat;
    logic             busy;

    modport master (
        output start,
        output cfg_window,
        output in_valid,
        output in_vec,
        output res_ready,
        input  in_ready,
        input  res_valid,
        input  res_toggles,
        input  res_out_toggles,
        input  res_sat,
        input  busy
    );

    modport slave (
        input  start,
        input  cfg_window,
        input  in_valid,
        input  in_vec,
        input  res_ready,
        output in_ready,
        output res_valid,
        output res_toggles,
        output res_out_toggles,
        output res_sat,
        output busy
    );

endinterface

// File: rtl/pwr_toggle_monitor_popcount.sv
// Combinational population count of a NET_W-bit vector.
// Shared by the activity monitors.
module pwr_popcount #(
    parameter int NET_W = 16,
    localparam int CW = $clog2(NET_W + 1)
) (
    input  logic [NET_W-1:0] vec,
    output logic [CW-1:0]    cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < NET_W; i++) begin
            cnt = cnt + CW'(vec[i]);
        end
    end

endmodule

// File: rtl/pwr_toggle_monitor.sv
// Windowed toggle counter for sampled net vectors.
// Reports total and output-net switching activity per window.
module pwr_toggle_monitor
    import pwr_mon_pkg::*;
#(
    parameter int NET_W = NET_W_D,
    parameter int CNT_W = CNT_W_D,
    parameter int WIN_W = WIN_W_D
) (
    input logic clk,
    input logic rst_n,
    pwr_toggle_monitor_if.slave bus
);

    localparam int PC_W = $clog2(NET_W + 1);
    localparam logic [31:0] CNT_MAX =
        32'((64'd1 << CNT_W) - 64'd1);

    mon_state_e state_q;
    mon_state_e state_d;

    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] ivl_q;
    logic [NET_W-1:0] prev_q;
    logic [CNT_W-1:0] tot_q;
    logic [CNT_W-1:0] out_q;
    logic             sat_q;

    logic [NET_W-1:0] diff;
    logic [PC_W-1:0]  pop;
    logic [WIN_W:0]   ivl_inc;
    logic [32:0]      tot_sum;
    logic [32:0]      out_sum;
    logic             tot_ovf;
    logic             out_ovf;
    logic             rdy;
    logic             take;
    logic             win_zero;
    logic             last_ivl;

    logic do_clear;
    logic do_base;
    logic do_accum;

    assign rdy  = (state_q == S_PRIME) |
                  (state_q == S_ACCUM);
    assign take = bus.in_valid & rdy;
    assign diff = bus.in_vec ^ prev_q;

    pwr_popcount #(
        .NET_W(NET_W)
    ) u_pop (
        .vec(diff),
        .cnt(pop)
    );

    assign win_zero = (bus.cfg_window == '0);
    assign ivl_inc  = {1'b0, ivl_q} +
                      {{WIN_W{1'b0}}, 1'b1};
    assign last_ivl = (ivl_inc == {1'b0, win_q});

    assign tot_sum = sat_add(32'(tot_q),
                             32'(pop), CNT_MAX);
    assign out_sum = sat_add(32'(out_q),
                             32'(diff[0]), CNT_MAX);

    // Upper bits of a clamped sum are zero unless it overflowed.
    assign tot_ovf = |tot_sum[32:CNT_W];
    assign out_ovf = |out_sum[32:CNT_W];

    always_comb begin
        state_d  = state_q;
        do_clear = 1'b0;
        do_base  = 1'b0;
        do_accum = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    do_clear = 1'b1;
                    state_d  = win_zero ? S_REPORT
                                        : S_PRIME;
                end
            end
            S_PRIME: begin
                if (take) begin
                    do_base = 1'b1;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (take) begin
                    do_accum = 1'b1;
                    if (last_ivl) begin
                        state_d = S_REPORT;
                    end
                end
            end
            S_REPORT: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            ivl_q   <= '0;
            prev_q  <= '0;
            tot_q   <= '0;
            out_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (do_clear) begin
                win_q <= bus.cfg_window;
                ivl_q <= '0;
                tot_q <= '0;
                out_q <= '0;
                sat_q <= 1'b0;
            end
            if (do_base) begin
                prev_q <= bus.in_vec;
            end
            if (do_accum) begin
                prev_q <= bus.in_vec;
                ivl_q  <= ivl_inc[WIN_W-1:0];
                tot_q  <= tot_sum[CNT_W-1:0];
                out_q  <= out_sum[CNT_W-1:0];
                sat_q  <= sat_q | tot_ovf | out_ovf;
            end
        end
    end

    assign bus.in_ready        = rdy;
    assign bus.res_valid       = (state_q == S_REPORT);
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.res_toggles     = tot_q;
    assign bus.res_out_toggles = out_q;
    assign bus.res_sat         = sat_q;

endmodule

// File: tb/tb_pwr_toggle_monitor.sv
// Scoreboard bench: a default-width and a 4-bit-counter monitor
// run the same stream and are checked against a window-sum model.
module tb_pwr_toggle_monitor;

    localparam int NW = 16;
    localparam int WW = 16;
    localparam int CA = 24;
    localparam int CB = 4;

    typedef struct {
        longint tot;
        longint outt;
        longint sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [WW-1:0] cfg = '0;
    logic          in_valid = 1'b0;
    logic [NW-1:0] in_vec = '0;
    logic          res_ready = 1'b0;

    pwr_toggle_monitor_if #(.NET_W(NW), .CNT_W(CA), .WIN_W(WW)) ia ();
    pwr_toggle_monitor_if #(.NET_W(NW), .CNT_W(CB), .WIN_W(WW)) ib ();

    assign ia.start = start;
    assign ia.cfg_window = cfg;
    assign ia.in_valid = in_valid;
    assign ia.in_vec = in_vec;
    assign ia.res_ready = res_ready;
    assign ib.start = start;
    assign ib.cfg_window = cfg;
    assign ib.in_valid = in_valid;
    assign ib.in_vec = in_vec;
    assign ib.res_ready = res_ready;

    pwr_toggle_monitor #(.NET_W(NW), .CNT_W(CA), .WIN_W(WW)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(ia)
    );
    pwr_toggle_monitor #(.NET_W(NW), .CNT_W(CB), .WIN_W(WW)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(ib)
    );

    int npass = 0;
    int ntot = 0;
    longint cyc = 0;
    longint last_evt = -10;
    exp_t qa[$];
    exp_t qb[$];
    logic [NW-1:0] sq[$];

    function automatic void chk(input string nm, input longint act,
                                input longint exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endfunction

    task automatic finish_run();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    endtask

    task automatic timeout(input string nm);
        chk(nm, 0, 1);
        finish_run();
    endtask

    // Reference: sum of per-interval Hamming distances, then clamp.
    function automatic exp_t model(input logic [NW-1:0] s[$],
                                   input int cw);
        exp_t e;
        longint t = 0;
        longint o = 0;
        longint mx = (64'd1 << cw) - 1;
        for (int i = 1; i < s.size(); i++) begin
            t += $countones(s[i] ^ s[i-1]);
            o += (s[i][0] != s[i-1][0]) ? 1 : 0;
        end
        e.sat = (t > mx || o > mx) ? 1 : 0;
        e.tot = (t > mx) ? mx : t;
        e.outt = (o > mx) ? mx : o;
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compares every cycle a result is shown, pops on handshake.
    initial begin
        bit rv_prev = 0;
        bit post_hs = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rv_prev = 0;
                post_hs = 0;
            end else begin
                if (post_hs) begin
                    chk("hs_drop_valid", ia.res_valid, 0);
                    chk("hs_idle", ia.busy, 0);
                    post_hs = 0;
                end
                if (ia.res_valid) begin
                    if (!rv_prev) chk("latency", cyc, last_evt + 1);
                    chk("lockstep_valid", ib.res_valid, 1);
                    chk("report_ready_low", ia.in_ready, 0);
                    if (qa.size() == 0 || qb.size() == 0) begin
                        chk("unexpected_result", 0, 1);
                    end else begin
                        chk("a_toggles", ia.res_toggles, qa[0].tot);
                        chk("a_out", ia.res_out_toggles, qa[0].outt);
                        chk("a_sat", ia.res_sat, qa[0].sat);
                        chk("b_toggles", ib.res_toggles, qb[0].tot);
                        chk("b_out", ib.res_out_toggles, qb[0].outt);
                        chk("b_sat", ib.res_sat, qb[0].sat);
                        if (res_ready) begin
                            void'(qa.pop_front());
                            void'(qb.pop_front());
                            post_hs = 1;
                        end
                    end
                end
                if (in_valid && ia.in_ready) last_evt = cyc;
                if (start && !ia.busy) last_evt = cyc;
                rv_prev = ia.res_valid;
            end
        end
    end

    task automatic check_reset_state();
        @(negedge clk);
        chk("rst_valid", ia.res_valid, 0);
        chk("rst_busy", ia.busy, 0);
        chk("rst_ready", ia.in_ready, 0);
        chk("rst_tot", ia.res_toggles, 0);
        chk("rst_out", ia.res_out_toggles, 0);
        chk("rst_sat", ia.res_sat, 0);
        chk("rst_b_busy", ib.busy, 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!ia.busy) return;
        end
        timeout("wait_idle_timeout");
    endtask

    task automatic send_sample(input logic [NW-1:0] v, input int gap);
        repeat (gap) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_vec = v;
        for (int i = 0; i <= 200; i++) begin
            @(negedge clk);
            if (ia.in_ready) break;
            if (i == 200) timeout("in_ready_timeout");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_vec = NW'($urandom);
    endtask

    task automatic do_start(input int win);
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg = WW'(win);
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg = WW'($urandom);
    endtask

    task automatic collect(input int stall, input bit ign_hs);
        for (int i = 0; i <= 200; i++) begin
            @(negedge clk);
            if (ia.res_valid) break;
            if (i == 200) timeout("res_valid_timeout");
        end
        repeat (stall) @(negedge clk);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        if (ign_hs) begin
            start = 1'b1;
            cfg = WW'($urandom_range(1, 9));
        end
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        start = 1'b0;
    endtask

    // gap < 0 picks a random 0..3 idle gap before each sample.
    task automatic run_window(input int gap, input int stall,
                              input bit ign_acc, input bit ign_hs);
        int win;
        win = (sq.size() == 0) ? 0 : sq.size() - 1;
        wait_idle();
        qa.push_back(model(sq, CA));
        qb.push_back(model(sq, CB));
        do_start(win);
        if (win == 0) chk("zero_win_ready", ia.in_ready, 0);
        for (int i = 0; i < sq.size(); i++) begin
            send_sample(sq[i], gap < 0 ? $urandom_range(0, 3) : gap);
            if (ign_acc && i == 2 && win >= 3) begin
                start = 1'b1;
                cfg = WW'($urandom_range(1, 9));
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        collect(stall, ign_hs);
    endtask

    initial begin
        logic [NW-1:0] v;
        int n;
        rst_n = 1'b0;
        check_reset_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        sq = '{16'h0000, 16'h0001, 16'h0003, 16'h0003, 16'hFFFF};
        run_window(0, 0, 0, 0);
        run_window(3, 5, 0, 0);

        sq = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
        run_window(0, 1, 0, 0);

        sq = {};
        run_window(0, 2, 0, 0);

        // Abort a window after two counted intervals.
        wait_idle();
        do_start(5);
        send_sample(16'h1234, 0);
        send_sample(16'hFFFF, 0);
        send_sample(16'h0F0F, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        check_reset_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sq = '{16'h0000, 16'h00FF, 16'h0000};
        run_window(0, 0, 0, 0);

        sq = '{16'hA5A5, 16'h5A5A, 16'h0001, 16'h0000, 16'h8001};
        run_window(1, 2, 1, 1);

        for (int w = 0; w < 30; w++) begin
            n = $urandom_range(0, 12);
            sq = {};
            v = NW'($urandom);
            if (n != 0) begin
                for (int i = 0; i <= n; i++) begin
                    if ($urandom_range(0, 3) != 0) v = NW'($urandom);
                    sq.push_back(v);
                end
            end
            run_window(-1, $urandom_range(0, 3),
                       1'($urandom), 1'($urandom));
        end

        wait_idle();
        chk("queues_drained", qa.size() + qb.size(), 0);
        finish_run();
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0 want 1");
        $fatal(1);
    end

endmodule
